// File: rtl/mul_req_scheduler.sv
// Round-robin scheduler that shares one fixed-latency pipelined multiplier among NREQ requesters.
// Issued ops are tracked beside the multiplier pipe; products land in a credit-guarded result FIFO.
module mul_req_scheduler #(
    parameter int N      = 16,
    parameter int M      = 16,
    parameter int LAT    = 16,
    parameter int NREQ   = 4,
    parameter int FDEPTH = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*N-1:0]       req_md,
    input  logic [NREQ*M-1:0]       req_mr,
    output logic [NREQ-1:0]         gnt,
    output logic [N-1:0]            mul_md,
    output logic [M-1:0]            mul_mr,
    input  logic [N+M-1:0]          mul_product,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [N+M-1:0]          res_product,
    output logic                    busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int PW  = N + M;
    localparam int FPW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int FCW = $clog2(FDEPTH + 1);
    localparam int ICW = $clog2(LAT + 1);
    localparam int OCW = $clog2(LAT + FDEPTH + 1) + 1;

    function automatic logic [FPW-1:0] fifo_inc(input logic [FPW-1:0] p);
        if (p == FPW'(FDEPTH - 1)) begin
            return '0;
        end else begin
            return p + FPW'(1);
        end
    endfunction

    logic [IDW-1:0] ptr_r;
    logic [LAT-1:0] vld_r;
    logic [IDW-1:0] id_r [LAT];
    logic [ICW-1:0] inflight_cnt_r;
    logic [FCW-1:0] fifo_cnt_r;
    logic [FPW-1:0] wr_ptr_r;
    logic [FPW-1:0] rd_ptr_r;
    logic [IDW-1:0] mem_id_r [FDEPTH];
    logic [PW-1:0]  mem_prod_r [FDEPTH];
    logic           res_valid_r;
    logic [IDW-1:0] res_id_r;
    logic [PW-1:0]  res_product_r;
    logic           busy_r;

    logic           pop_s;
    logic           push_s;
    logic           issue_ok_s;
    logic           found_s;
    logic           hit_s;
    logic           transfer_s;
    logic [OCW-1:0] occ_s;
    logic [IDW-1:0] cand_s;
    logic [IDW-1:0] gnt_idx_s;
    logic [NREQ-1:0] gnt_s;
    logic [ICW-1:0] inflight_nxt_s;
    logic [FCW-1:0] fifo_nxt_s;
    logic [FPW-1:0] rd_nxt_s;
    logic [IDW-1:0] head_id_s;
    logic [PW-1:0]  head_prod_s;

    // Credit check: a pop this cycle frees its slot for an issue in the same cycle
    always_comb begin
        pop_s      = res_valid_r & res_ready;
        push_s     = vld_r[LAT-1];
        occ_s      = OCW'(inflight_cnt_r) + OCW'(fifo_cnt_r) - OCW'(pop_s);
        issue_ok_s = (occ_s < OCW'(FDEPTH));
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        found_s   = 1'b0;
        hit_s     = 1'b0;
        gnt_idx_s = '0;
        cand_s    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s    = IDW'((int'(ptr_r) + k) % NREQ);
            hit_s     = req[cand_s] & ~found_s;
            gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
            found_s   = found_s | hit_s;
        end
        transfer_s       = found_s & issue_ok_s;
        gnt_s            = '0;
        gnt_s[gnt_idx_s] = transfer_s;
    end

    assign gnt = gnt_s;

    // Operand steering into the shared multiplier; zero when nothing is issued
    always_comb begin
        mul_md = '0;
        mul_mr = '0;
        if (transfer_s) begin
            mul_md = req_md[int'(gnt_idx_s)*N +: N];
            mul_mr = req_mr[int'(gnt_idx_s)*M +: M];
        end else begin
            mul_md = '0;
            mul_mr = '0;
        end
    end

    // Next occupancy and next FIFO head; an empty FIFO forwards the entry being pushed
    always_comb begin
        inflight_nxt_s = inflight_cnt_r + ICW'(transfer_s) - ICW'(push_s);
        fifo_nxt_s     = fifo_cnt_r + FCW'(push_s) - FCW'(pop_s);
        rd_nxt_s       = pop_s ? fifo_inc(rd_ptr_r) : rd_ptr_r;
        if (fifo_nxt_s == '0) begin
            head_id_s   = '0;
            head_prod_s = '0;
        end else if (push_s && (fifo_cnt_r == FCW'(pop_s))) begin
            head_id_s   = id_r[LAT-1];
            head_prod_s = mul_product;
        end else begin
            head_id_s   = mem_id_r[rd_nxt_s];
            head_prod_s = mem_prod_r[rd_nxt_s];
        end
    end

    // Arbitration pointer, issue tracking pipe and occupancy counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r          <= IDW'(NREQ - 1);
            vld_r          <= '0;
            for (int i = 0; i < LAT; i++) begin
                id_r[i] <= '0;
            end
            inflight_cnt_r <= '0;
            fifo_cnt_r     <= '0;
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
        end else begin
            if (transfer_s) begin
                ptr_r <= gnt_idx_s;
            end
            vld_r   <= {vld_r[LAT-2:0], transfer_s};
            id_r[0] <= gnt_idx_s;
            for (int i = 1; i < LAT; i++) begin
                id_r[i] <= id_r[i-1];
            end
            inflight_cnt_r <= inflight_nxt_s;
            fifo_cnt_r     <= fifo_nxt_s;
            rd_ptr_r       <= rd_nxt_s;
            if (push_s) begin
                wr_ptr_r <= fifo_inc(wr_ptr_r);
            end
        end
    end

    // Result storage; the tracking tail lines up with the multiplier output
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_id_r[wr_ptr_r]   <= id_r[LAT-1];
            mem_prod_r[wr_ptr_r] <= mul_product;
        end
    end

    // Registered result head and activity flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_r   <= 1'b0;
            res_id_r      <= '0;
            res_product_r <= '0;
            busy_r        <= 1'b0;
        end else begin
            res_valid_r   <= (fifo_nxt_s != '0);
            res_id_r      <= head_id_s;
            res_product_r <= head_prod_s;
            busy_r        <= (inflight_nxt_s != '0) | (fifo_nxt_s != '0);
        end
    end

    assign res_valid   = res_valid_r;
    assign res_id      = res_id_r;
    assign res_product = res_product_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mul_req_scheduler.sv
// Bench for mul_req_scheduler: external multiplier model, ordered-queue reference model,
// a table of single-op vectors and directed multi-cycle sequences plus a random phase.
module tb_mul_req_scheduler;
    localparam int N = 16, M = 16, LAT = 16, NREQ = 4, FDEPTH = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_md;
    logic [NREQ*M-1:0] req_mr;
    logic [NREQ-1:0]   gnt;
    logic [N-1:0]      mul_md;
    logic [M-1:0]      mul_mr;
    logic [N+M-1:0]    mul_product;
    logic              res_valid;
    logic              res_ready;
    logic [1:0]        res_id;
    logic [N+M-1:0]    res_product;
    logic              busy;

    mul_req_scheduler #(.N(N), .M(M), .LAT(LAT), .NREQ(NREQ), .FDEPTH(FDEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .req_md(req_md), .req_mr(req_mr), .gnt(gnt),
        .mul_md(mul_md), .mul_mr(mul_mr), .mul_product(mul_product),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_product(res_product), .busy(busy)
    );

    always #5 clk = ~clk;

    // LAT-stage multiplier with no handshake; it keeps running through reset
    logic [N+M-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= {16'd0, mul_md} * {16'd0, mul_mr};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_product = pipe[LAT-1];

    typedef struct { int id; logic [31:0] prod; int ready_cyc; } op_t;
    typedef struct { int rid; logic [15:0] md; logic [15:0] mr; logic [31:0] prod; logic [3:0] egnt; } vec_t;

    op_t  q[$];
    int   m_ptr, cyc, checks, errors, last_gnt;
    int   issued [NREQ];
    int   returned [NREQ];
    int   kc [NREQ];
    logic s_valid, s_busy;
    logic [1:0]  s_id;
    logic [31:0] s_prod;
    logic [3:0]  s_gnt;
    logic [NREQ-1:0] pend;
    vec_t vt [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, compare against the queue model, advance model at posedge
    task automatic step(input logic [NREQ-1:0] r, input logic rdy);
        logic exp_v;
        int   pop, g;
        logic [NREQ-1:0] exp_g;
        logic [15:0] md, mr;
        req = r;
        res_ready = rdy;
        #2;
        s_valid = res_valid; s_id = res_id; s_prod = res_product; s_busy = busy; s_gnt = gnt;
        exp_v = (q.size() > 0) && (q[0].ready_cyc <= cyc);
        pop = (exp_v && rdy) ? 1 : 0;
        g = -1;
        if (q.size() - pop < FDEPTH)
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && r[2'((m_ptr + k) % NREQ)]) g = (m_ptr + k) % NREQ;
        exp_g = '0;
        if (g >= 0) exp_g[2'(g)] = 1'b1;
        check("gnt", 64'(gnt), 64'(exp_g));
        check("res_valid", 64'(res_valid), 64'(exp_v));
        if (exp_v) begin
            check("res_id", 64'(res_id), 64'(q[0].id));
            check("res_product", 64'(res_product), 64'(q[0].prod));
        end
        check("busy", 64'(busy), 64'(q.size() != 0));
        if (res_valid && rdy) returned[res_id]++;
        if (pop != 0) void'(q.pop_front());
        if (g >= 0) begin
            md = req_md[g*N +: N];
            mr = req_mr[g*M +: M];
            q.push_back('{g, {16'd0, md} * {16'd0, mr}, cyc + LAT + 1});
            m_ptr = g;
            issued[2'(g)]++;
        end
        last_gnt = g;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b0;
        #1;
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_res_id", 64'(res_id), 64'(0));
        check("rst_res_product", 64'(res_product), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        m_ptr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin issued[i] = 0; returned[i] = 0; end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        s_busy = 1'b1;
        while (s_busy && n < bound) begin step('0, 1'b1); n++; end
        check("drain_idle", 64'(s_busy), 64'(0));
    endtask

    task automatic set_ops(input int i);
        req_md[i*N +: N] = 16'(16 * i + kc[i]);
        req_mr[i*M +: M] = 16'(16 * i + kc[i] + 5);
    endtask

    task automatic run_single(input vec_t v);
        logic [NREQ-1:0] r;
        int lat;
        r = '0;
        r[2'(v.rid)] = 1'b1;
        req_md = '0; req_mr = '0;
        req_md[v.rid*N +: N] = v.md;
        req_mr[v.rid*M +: M] = v.mr;
        step(r, 1'b1);
        check("single_gnt", 64'(s_gnt), 64'(v.egnt));
        lat = 0;
        s_valid = 1'b0;
        while (!s_valid && lat < LAT + 4) begin step('0, 1'b1); lat++; end
        check("single_latency", 64'(lat), 64'(LAT + 1));
        check("single_id", 64'(s_id), 64'(v.rid));
        check("single_product", 64'(s_prod), 64'(v.prod));
        step('0, 1'b1);
        check("single_busy_after_pop", 64'(s_busy), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] e;
        int ng;
        vt[0] = '{2, 16'h0003, 16'h0005, 32'h0000_000F, 4'b0100};
        vt[1] = '{0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'b0001};
        vt[2] = '{1, 16'h0000, 16'hFFFF, 32'h0000_0000, 4'b0010};
        vt[3] = '{3, 16'h1234, 16'h5678, 32'h0626_0060, 4'b1000};
        vt[4] = '{3, 16'h8000, 16'h0002, 32'h0001_0000, 4'b1000};
        checks = 0; errors = 0; cyc = 0; m_ptr = NREQ - 1; last_gnt = -1;
        rst = 1'b0; req = '0; req_md = '0; req_mr = '0; res_ready = 1'b0; pend = '0;
        for (int i = 0; i < NREQ; i++) kc[i] = 0;
        @(negedge clk);
        do_reset();

        for (int v = 0; v < 5; v++) run_single(vt[v]);

        // Held req[1] with req[3] toggling: pointer rotation must pick 3 after 1
        for (int i = 0; i < NREQ; i++) set_ops(i);
        step(4'b0001, 1'b1);
        step(4'b1010, 1'b1);
        check("prio_first", 64'(s_gnt), 64'(4'b0010));
        step(4'b0010, 1'b1);
        step(4'b1010, 1'b1);
        check("prio_rotate", 64'(s_gnt), 64'(4'b1000));
        drain(60);

        // All requesters held high: strict 0,1,2,3 rotation from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin kc[i] = 0; set_ops(i); end
        for (int n = 0; n < 24; n++) begin
            step(4'hF, 1'b1);
            e = '0;
            e[2'(n % NREQ)] = 1'b1;
            check("fair_gnt", 64'(s_gnt), 64'(e));
            if (last_gnt >= 0) begin kc[last_gnt]++; set_ops(last_gnt); end
        end
        drain(LAT + 10);

        // Backpressure: credit admits exactly FDEPTH ops, then one per pop
        ng = 0;
        for (int n = 0; n < LAT + FDEPTH + 4; n++) begin
            step(4'hF, 1'b0);
            if (s_gnt != '0) ng++;
            if (last_gnt >= 0) begin kc[last_gnt]++; set_ops(last_gnt); end
        end
        check("bp_grant_count", 64'(ng), 64'(FDEPTH));
        check("bp_gnt_blocked", 64'(s_gnt), 64'(0));
        for (int n = 0; n < 30; n++) begin
            step(4'hF, 1'b1);
            if (last_gnt >= 0) begin kc[last_gnt]++; set_ops(last_gnt); end
        end
        drain(FDEPTH + LAT + 10);

        // Reset while ops are in flight: nothing may emerge afterwards
        for (int n = 0; n < 5; n++) step(4'hF, 1'b1);
        for (int n = 0; n < 3; n++) step('0, 1'b1);
        do_reset();
        for (int n = 0; n < 2 * LAT; n++) begin
            step('0, 1'b1);
            check("post_rst_quiet", 64'({s_valid, s_busy}), 64'(0));
        end
        run_single('{1, 16'h0007, 16'h0009, 32'h0000_003F, 4'b0010});

        // Random requests held until granted, random drain readiness
        for (int c = 0; c < 100; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!pend[2'(i)] && $urandom_range(0, 1) == 1) begin
                    pend[2'(i)] = 1'b1;
                    req_md[i*N +: N] = 16'($urandom);
                    req_mr[i*M +: M] = 16'($urandom);
                end
            step(pend, ($urandom_range(0, 3) != 0));
            if (last_gnt >= 0) pend[2'(last_gnt)] = 1'b0;
        end
        for (int c = 0; c < 200 && pend != '0; c++) begin
            step(pend, 1'b1);
            if (last_gnt >= 0) pend[2'(last_gnt)] = 1'b0;
        end
        drain(FDEPTH + LAT + 10);
        for (int i = 0; i < NREQ; i++) check("sb_returned", 64'(returned[i]), 64'(issued[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_req_scheduler.md
Name: mul_req_scheduler

Overview:
- Shares one PIPELINED_MUL instance (LAT-stage, no valid/stall) between NREQ requesters.
- Round-robin arbitration each cycle issues at most one operand pair into the multiplier.
- Tracks in-flight operations with a LAT-deep valid/ID shift register.
- Buffers finished products in a result FIFO with valid/ready drain; issue is credit-limited so a result is never dropped.

Parameters:
- N, 16, multiplicand width
- M, 16, multiplier width
- LAT, 16, multiplier pipeline depth in cycles (equals M for PIPELINED_MUL)
- NREQ, 4, number of requesters (>=2)
- FDEPTH, 20, result FIFO depth (>= LAT+1 for full throughput under ready=1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request; must hold with stable operands until granted
- req_md  in  NREQ*N  multiplicands, requester i at [i*N +: N]
- req_mr  in  NREQ*M  multipliers, requester i at [i*M +: M]
- gnt  out  NREQ  one-hot grant, combinational; transfer = req[i]&gnt[i]
- mul_md  out  N  to multiplier multiplicand
- mul_mr  out  M  to multiplier multiplier
- mul_product  in  N+M  from multiplier Product
- res_valid  out  1  result FIFO head valid
- res_ready  in  1  consumer accepts head
- res_id  out  clog2(NREQ)  requester index of head result
- res_product  out  N+M  head product
- busy  out  1  any op in flight or FIFO non-empty

Behaviour:
- Reset (rst=0, async): RR pointer -> NREQ-1 (so requester 0 has first priority); shift register valids -> 0; FIFO empty; res_valid=0, res_id=0, res_product=0, busy=0.
- Reset mid-operation discards all in-flight and buffered results, with no output afterwards.
- The multiplier keeps running its own pipeline during reset. Its stale outputs are ignored because all tracking valids are 0.
- Credit: occ = inflight_count + fifo_count. Issue is allowed only when occ < FDEPTH.
  - Count a FIFO pop in the same cycle as a credit.
  - Do not count a push in the same cycle as a new credit; it is already counted in inflight.
- Arbitration: when issue is allowed and any req is high, grant the first requester with req=1 searching from (ptr+1) mod NREQ upward with wrap.
  - ptr <- granted index on transfer.
  - At most one gnt bit is set.
  - gnt=0 when no req or when credit is exhausted.
- Operand drive:
  - Granted: mul_md/mul_mr = granted requester's operands.
  - Idle: both 0.
  - The multiplier samples them at the edge ending the transfer cycle t.
- Tracking: stage 0 of the valid/ID shift register loads (transfer, index) at the same edge. It shifts every cycle unconditionally.
- Product timing: stage LAT-1 is valid in cycle t+LAT, which is when mul_product holds the product of the pair issued in cycle t.
- FIFO push: at the end of cycle t+LAT, when the tracking tail is valid, push {id, mul_product}.
  - Push is never refused; credit guarantees space.
- Output:
  - res_valid/res_id/res_product reflect the registered FIFO head.
  - Pop on res_valid & res_ready.
  - Minimum issue-to-res_valid latency is LAT+1 cycles.
  - Results emerge in issue order.
- Simultaneous push and pop:
  - FIFO non-empty: both happen and the count is unchanged.
  - FIFO empty: the pushed entry becomes head next cycle.
  - Pointers wrap modulo FDEPTH.
- Arithmetic: unsigned N x M -> N+M bits. Full-scale operands produce no truncation.
- busy = (inflight_count != 0) | (fifo_count != 0).

Test Plan:
- Single op: req[2]=1, md=0x0003, mr=0x0005 -> gnt[2] same cycle; res_valid exactly LAT+1 cycles later with res_id=2, res_product=0x0000000F; busy falls after pop.
- Full scale: md=0xFFFF, mr=0xFFFF -> res_product=0xFFFE0001; md=0, mr=0xFFFF -> 0.
- Fairness: all four req held high, res_ready=1 -> grants 0,1,2,3,0,1... one per cycle; results back-to-back in the same ID order, each product correct (operands = 0x10*i + k).
- Backpressure: res_ready=0, all req high.
  - Exactly FDEPTH grants, then gnt=0.
  - No result is lost.
  - Set res_ready=1: one grant resumes per pop; all FDEPTH+further results arrive in order.
- Reset mid-flight: issue 5 ops, assert rst=0 after 3 cycles for 2 cycles -> res_valid stays 0 for the following 2*LAT cycles, busy=0; a new op then completes normally with ID/product correct.
- Priority hold: req[1] only, held 3 cycles while req[3] toggles -> ptr rotation grants 3 after 1; no requester is starved over 100 random cycles (scoreboard checks every issued op returns once).
